corr_stim_sequencer: RTL and testbench

// Hardware stimulus scheduler for power/EM correlation runs on the masked 2-gate cell (a, b, r1, r2 -> y).

---
 rtl/corr_stim_sequencer.sv | 158 +++++++++++++++
 tb/tb_corr_stim_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/corr_stim_sequencer.sv
// Stimulus scheduler for masked-cell correlation runs: sweeps every ordered pair (i, j)
// of input vectors, holding i then j (under trig), and hands each finished trace to the capture side.
module corr_stim_sequencer #(
    parameter int N_IN     = 4,
    parameter int HOLD_CYC = 5,
    parameter int IDX_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             rec_ack,
    output logic [N_IN-1:0]  dut_in,
    output logic             trig,
    output logic             rec_valid,
    output logic [IDX_W-1:0] sim_idx,
    output logic             busy,
    output logic             done,
    output logic [2:0]       state_dbg
);

    localparam int HC_W = $clog2(HOLD_CYC + 1);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYC - 1);
    localparam logic [N_IN-1:0] VEC_MAX   = '1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRE      = 3'd1,
        TRANS    = 3'd2,
        WAIT_ACK = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t          state, state_nx;
    logic [N_IN-1:0] i, i_nx;
    logic [N_IN-1:0] j, j_nx;
    logic [HC_W-1:0] hold_cnt, hold_nx;
    logic [N_IN-1:0] dut_in_nx;
    logic            trig_nx;
    logic            rec_valid_nx;
    logic            busy_nx;
    logic            done_nx;
    logic            in_sweep;

    assign sim_idx   = {i, j};
    assign state_dbg = state;
    assign in_sweep  = (state == PRE) || (state == TRANS) || (state == WAIT_ACK);

    // Handshake: rec_valid rises when a pair's trace is complete and stays high, with
    // sim_idx and dut_in frozen, until rec_ack is sampled high on a rising edge; that
    // edge is the transfer and the sweep moves to the next pair on the same edge.
    always_comb begin
        state_nx     = state;
        i_nx         = i;
        j_nx         = j;
        hold_nx      = hold_cnt;
        dut_in_nx    = dut_in;
        trig_nx      = trig;
        rec_valid_nx = rec_valid;
        busy_nx      = busy;
        done_nx      = done;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx     = PRE;
                    i_nx         = '0;
                    j_nx         = '0;
                    hold_nx      = '0;
                    dut_in_nx    = '0;
                    trig_nx      = 1'b0;
                    rec_valid_nx = 1'b0;
                    busy_nx      = 1'b1;
                    done_nx      = 1'b0;
                end
            end
            PRE: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nx  = TRANS;
                    dut_in_nx = j;
                    trig_nx   = 1'b1;
                    hold_nx   = '0;
                end else begin
                    hold_nx = hold_cnt + 1'b1;
                end
            end
            TRANS: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nx     = WAIT_ACK;
                    trig_nx      = 1'b0;
                    rec_valid_nx = 1'b1;
                    hold_nx      = '0;
                end else begin
                    hold_nx = hold_cnt + 1'b1;
                end
            end
            WAIT_ACK: begin
                if (rec_ack) begin
                    rec_valid_nx = 1'b0;
                    if (j != VEC_MAX) begin
                        j_nx      = j + 1'b1;
                        dut_in_nx = i;
                        state_nx  = PRE;
                    end else if (i != VEC_MAX) begin
                        j_nx      = '0;
                        i_nx      = i + 1'b1;
                        dut_in_nx = i + 1'b1;
                        state_nx  = PRE;
                    end else begin
                        // Last pair: i, j and dut_in stay on (max, max).
                        state_nx = DONE;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // Abort overrides any handshake or hold progress in the same cycle.
        if (abort && in_sweep) begin
            state_nx     = IDLE;
            hold_nx      = '0;
            dut_in_nx    = '0;
            trig_nx      = 1'b0;
            rec_valid_nx = 1'b0;
            busy_nx      = 1'b0;
            done_nx      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            i         <= '0;
            j         <= '0;
            hold_cnt  <= '0;
            dut_in    <= '0;
            trig      <= 1'b0;
            rec_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            i         <= i_nx;
            j         <= j_nx;
            hold_cnt  <= hold_nx;
            dut_in    <= dut_in_nx;
            trig      <= trig_nx;
            rec_valid <= rec_valid_nx;
            busy      <= busy_nx;
            done      <= done_nx;
        end
    end

endmodule

// File: tb/tb_corr_stim_sequencer.sv
// Bench for corr_stim_sequencer: expected pair ordinals are queued at each start and
// popped by a negedge monitor on every rec_valid/rec_ack transfer.
module tb_corr_stim_sequencer;

    localparam int N_IN     = 4;
    localparam int HOLD_CYC = 5;
    localparam int IDX_W    = 8;
    localparam int NPAIRS   = (1 << N_IN) * (1 << N_IN);

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic             rec_ack;
    logic [N_IN-1:0]  dut_in;
    logic             trig;
    logic             rec_valid;
    logic [IDX_W-1:0] sim_idx;
    logic             busy;
    logic             done;
    logic [2:0]       state_dbg;

    int checks = 0;
    int errors = 0;
    int rec_cnt = 0;
    logic [IDX_W-1:0] exp_q[$];

    bit ack_tied = 0;
    bit ack_en   = 0;

    corr_stim_sequencer #(
        .N_IN    (N_IN),
        .HOLD_CYC(HOLD_CYC),
        .IDX_W   (IDX_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .rec_ack  (rec_ack),
        .dut_in   (dut_in),
        .trig     (trig),
        .rec_valid(rec_valid),
        .sim_idx  (sim_idx),
        .busy     (busy),
        .done     (done),
        .state_dbg(state_dbg)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a sweep visits ordinal i*2^N + j for i, j in ascending order.
    task automatic push_sweep();
        exp_q.delete();
        rec_cnt = 0;
        for (int a = 0; a < (1 << N_IN); a++)
            for (int b = 0; b < (1 << N_IN); b++)
                exp_q.push_back(IDX_W'(a * (1 << N_IN) + b));
    endtask

    task automatic pulse_start();
        @(posedge clk) #1 start = 1'b1;
        push_sweep();
        @(posedge clk) #1 start = 1'b0;
    endtask

    // mode 0: first PRE cycle of pair idx, 1: TRANS of idx, 2: WAIT_ACK of idx, 3: done
    task automatic wait_for(input string name, input int mode, input logic [IDX_W-1:0] idx,
                            input int budget);
        bit hit = 0;
        for (int n = 0; n < budget && !hit; n++) begin
            @(negedge clk);
            case (mode)
                0: hit = busy && !trig && !rec_valid && (sim_idx == idx);
                1: hit = trig && (sim_idx == idx);
                2: hit = rec_valid && (sim_idx == idx);
                default: hit = done;
            endcase
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s timeout after %0d cycles, wanted condition not reached", name, budget);
        end
    endtask

    // Capture-side responder: tied high, off, or acking after a random delay.
    initial begin
        int ack_wait = 0;
        int ack_dly  = 0;
        rec_ack = 1'b0;
        forever begin
            @(posedge clk) #1;
            if (ack_tied) begin
                rec_ack = 1'b1;
            end else if (!ack_en) begin
                rec_ack  = 1'b0;
                ack_wait = 0;
            end else if (rec_ack) begin
                rec_ack = 1'b0;
            end else if (rec_valid) begin
                if (ack_wait == 0)
                    ack_dly = (sim_idx == 8'h3A) ? 7 : int'($urandom_range(0, 3));
                if (ack_wait >= ack_dly) begin
                    rec_ack  = 1'b1;
                    ack_wait = 0;
                end else begin
                    ack_wait++;
                end
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        bit p_rv = 0, p_ack = 0, p_ctl = 1, p_trig = 0, p_pre = 0, cur_pre;
        logic [IDX_W-1:0] p_idx = '0;
        logic [N_IN-1:0]  p_din = '0;
        logic [IDX_W-1:0] e;
        int pre_len = 0, trig_len = 0;
        forever begin
            @(negedge clk);
            cur_pre = busy && !trig && !rec_valid;
            if (!rst && !abort && !p_ctl) begin
                if (p_rv && !p_ack) begin
                    chk("rv_hold", rec_valid, 1);
                    chk("idx_hold", sim_idx, p_idx);
                    chk("din_hold", dut_in, p_din);
                end
                if (p_pre && trig) chk("pre_len", pre_len, HOLD_CYC);
                if (p_trig && !trig && busy) chk("trig_len", trig_len, HOLD_CYC);
                if (cur_pre) chk("pre_din", dut_in, sim_idx[7:4]);
                if (trig) chk("trig_din", dut_in, sim_idx[3:0]);
                if (rec_valid && rec_ack) begin
                    rec_cnt++;
                    if (exp_q.size() == 0) begin
                        chk("rec_unexpected", sim_idx, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rec_idx", sim_idx, e);
                        chk("rec_din", dut_in, e[3:0]);
                    end
                end
            end
            pre_len  = cur_pre ? pre_len + 1 : 0;
            trig_len = trig ? trig_len + 1 : 0;
            p_rv   = rec_valid;
            p_ack  = rec_ack;
            p_idx  = sim_idx;
            p_din  = dut_in;
            p_trig = trig;
            p_pre  = cur_pre;
            p_ctl  = rst || abort;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // Driver sequence
    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_din", dut_in, 0);
        chk("rst_trig", trig, 0);
        chk("rst_rv", rec_valid, 0);
        chk("rst_idx", sim_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        // First pair timing with rec_ack tied high
        ack_tied = 1;
        @(posedge clk) #1 start = 1'b1;
        push_sweep();
        @(posedge clk) #1 start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("t1_din_c%0d", k), dut_in, 0);
            chk($sformatf("t1_trig_c%0d", k), trig, (k >= 6 && k <= 10));
            chk($sformatf("t1_rv_c%0d", k), rec_valid, (k == 11));
            chk($sformatf("t1_idx_c%0d", k), sim_idx, (k == 12) ? 1 : 0);
            chk($sformatf("t1_busy_c%0d", k), busy, 1);
        end

        // Full sweep to completion
        wait_for("sweep1_done", 3, '0, 5000);
        chk("s1_done", done, 1);
        chk("s1_busy", busy, 0);
        chk("s1_idx_last", sim_idx, 8'hFF);
        chk("s1_din_last", dut_in, 4'hF);
        chk("s1_q_empty", exp_q.size(), 0);
        chk("s1_rec_cnt", rec_cnt, NPAIRS);

        // Restart from DONE with random ack delays
        ack_tied = 0;
        ack_en   = 1;
        pulse_start();
        @(negedge clk);
        chk("rs_idx", sim_idx, 0);
        chk("rs_busy", busy, 1);
        chk("rs_done", done, 0);
        chk("rs_din", dut_in, 0);

        // Start while busy is ignored
        wait_for("pre_20", 0, 8'h20, 2000);
        pulse_start_ignored();
        @(negedge clk);
        chk("busy_start_idx", sim_idx, 8'h20);
        chk("busy_start_din", dut_in, 4'h2);
        chk("busy_start_busy", busy, 1);

        // Delayed ack on pair 0x3A holds outputs
        wait_for("wait_3a", 2, 8'h3A, 2000);
        for (int k = 0; k < 7; k++) begin
            if (k > 0) @(negedge clk);
            chk("stall_rv", rec_valid, 1);
            chk("stall_idx", sim_idx, 8'h3A);
            chk("stall_din", dut_in, 4'hA);
        end

        // Abort during TRANS of pair 0x51
        wait_for("trans_51", 1, 8'h51, 2000);
        @(posedge clk) #1 abort = 1'b1;
        exp_q.delete();
        @(posedge clk) #1 abort = 1'b0;
        @(negedge clk);
        chk("ab_trig", trig, 0);
        chk("ab_din", dut_in, 0);
        chk("ab_busy", busy, 0);
        chk("ab_done", done, 0);
        chk("ab_rv", rec_valid, 0);

        pulse_start();
        @(negedge clk);
        chk("ab_rs_idx", sim_idx, 0);
        chk("ab_rs_busy", busy, 1);
        chk("ab_rs_din", dut_in, 0);

        // Reset during WAIT_ACK; later acks are ignored
        wait_for("pre_13", 0, 8'h13, 2000);
        ack_en = 0;
        wait_for("wait_13", 2, 8'h13, 50);
        @(posedge clk) #1 rst = 1'b1;
        exp_q.delete();
        @(posedge clk) #1 rst = 1'b0;
        ack_tied = 1;
        @(negedge clk);
        chk("r5_din", dut_in, 0);
        chk("r5_trig", trig, 0);
        chk("r5_rv", rec_valid, 0);
        chk("r5_idx", sim_idx, 0);
        chk("r5_busy", busy, 0);
        chk("r5_done", done, 0);
        repeat (3) begin
            @(negedge clk);
            chk("r5_ack_busy", busy, 0);
            chk("r5_ack_rv", rec_valid, 0);
            chk("r5_ack_idx", sim_idx, 0);
        end
        ack_tied = 0;
        ack_en   = 1;

        // Final full sweep with random ack delays
        pulse_start();
        wait_for("sweep2_done", 3, '0, 9000);
        chk("s2_done", done, 1);
        chk("s2_busy", busy, 0);
        chk("s2_q_empty", exp_q.size(), 0);
        chk("s2_rec_cnt", rec_cnt, NPAIRS);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Start pulse issued mid-sweep: no expectations are queued for it.
    task automatic pulse_start_ignored();
        @(posedge clk) #1 start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
    endtask

endmodule
